// File: rtl/des_pkg.sv
// Shared DES substitution-layer definitions: S-box and P tables, FSM state type,
// lookup/permutation helpers and the LANES legality check.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each box is 64 nibbles, index 0 in the top nibble; rows are 16 nibbles each.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B3497D2C05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [3:0] sbox_lookup(logic [2:0] box, logic [5:0] chunk);
    logic [5:0] idx;
    idx = {chunk[5], chunk[0], chunk[4:1]};
    return SBOX[box][255 - 4 * int'(idx) -: 4];
  endfunction

  // Output bit i takes input bit P_TABLE[i-1]; bit 1 is the MSB on both sides.
  function automatic logic [1:32] p_perm(logic [1:32] x);
    logic [1:32] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i+1] = x[P_TABLE[i]];
    end
    return r;
  endfunction

  function automatic bit lanes_legal(int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
  endfunction

endpackage

// File: rtl/des_sbox_rom.sv
// One combinational DES S-box lookup: box select plus 6-bit chunk to 4-bit value.
module des_sbox_rom
  import des_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [5:0] chunk,
  output logic [3:0] value
);

  assign value = sbox_lookup(sel, chunk);

endmodule

// File: rtl/des_sbox_layer.sv
// Multi-cycle DES substitution layer, LANES boxes per cycle over 8/LANES cycles.
// Define DES_SBOX_PERM_EN to apply the P permutation on the final RUN edge.
module des_sbox_layer
  import des_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:48] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] out_data,
  output logic        busy
);

  localparam int STEPS  = 8 / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("des_sbox_layer: LANES must be 1, 2, 4 or 8");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid must be held until then, and the payload is stable while valid.
  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [1:48]         in_reg;
  logic [1:32]         out_reg;
  logic [1:32]         merged;
  logic [1:32]         final_word;
  logic [2:0]          box [LANES];
  logic [3:0]          nib [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign box[l] = 3'(int'(step) * LANES + l);
    des_sbox_rom u_rom (
      .sel   (box[l]),
      .chunk (in_reg[6 * int'(box[l]) + 1 +: 6]),
      .value (nib[l])
    );
  end

  always_comb begin
    merged = out_reg;
    for (int l = 0; l < LANES; l++) begin
      merged[4 * int'(box[l]) + 1 +: 4] = nib[l];
    end
`ifdef DES_SBOX_PERM_EN
    final_word = p_perm(merged);
`else
    final_word = merged;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= '0;
      in_reg  <= '0;
      out_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg  <= in_data;
            out_reg <= '0;
            step    <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          step <= step + STEP_W'(1);
          if (step == LAST_STEP) begin
            out_reg <= final_word;
            state   <= DONE;
          end else begin
            out_reg <= merged;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              in_reg  <= in_data;
              out_reg <= '0;
              step    <= '0;
              state   <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign out_data  = out_reg;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_des_sbox_layer.sv
// Directed bench for des_sbox_layer with LANES = 1, 2 and 8 instances side by side.
module tb_des_sbox_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [1:48] in_data   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [1:32] out_data  [3];
  logic        busy      [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  des_sbox_layer #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]));

  des_sbox_layer #(.LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]));

  des_sbox_layer #(.LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]));

  // Expected final word for a raw S1..S8 concatenation in the current build.
  function automatic logic [31:0] expw(logic [31:0] raw);
`ifdef DES_SBOX_PERM_EN
    int p [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    logic [1:32] x;
    logic [1:32] r;
    x = raw;
    r = '0;
    for (int i = 0; i < 32; i++) r[i+1] = x[p[i]];
    return r;
`else
    return raw;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int k, input int max, output int n);
    n = 0;
    while (out_valid[k] !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] held;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k]   = '0;
    end

    // Reset state
    tick();
    for (int k = 0; k < 3; k++) chk("in_ready_in_reset", 32'(in_ready[k]), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", 32'(in_ready[k]), 32'd1);
      chk("reset_out_valid", 32'(out_valid[k]), 32'd0);
      chk("reset_busy", 32'(busy[k]), 32'd0);
      chk("reset_out_data", out_data[k], 32'h0);
    end

    // LANES=8, zero input: one cycle latency
    out_ready[2] = 1'b1;
    in_data[2]   = 48'h0;
    in_valid[2]  = 1'b1;
    exp_q.push_back(expw(32'hEFA72C4D));
    tick();
    in_valid[2] = 1'b0;
    chk("l8_run_busy", 32'(busy[2]), 32'd1);
    chk("l8_run_no_valid", 32'(out_valid[2]), 32'd0);
    tick();
    chk("l8_valid", 32'(out_valid[2]), 32'd1);
    chk("l8_data", out_data[2], exp_q.pop_front());
    tick();
    chk("l8_back_idle", 32'({out_valid[2], busy[2]}), 32'd0);

    // LANES=1, all-ones input: eight cycles, busy throughout
    out_ready[0] = 1'b1;
    in_data[0]   = 48'hFFFFFFFFFFFF;
    in_valid[0]  = 1'b1;
    exp_q.push_back(expw(32'hD9CE3DCB));
    tick();
    in_valid[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("l1_running", 32'({out_valid[0], busy[0]}), 32'b01);
      tick();
    end
    chk("l1_valid_busy", 32'({out_valid[0], busy[0]}), 32'b11);
    chk("l1_data", out_data[0], exp_q.pop_front());
    tick();
    chk("l1_idle", 32'({out_valid[0], busy[0]}), 32'd0);

    // LANES=2, only S7 chunk all-ones, then a 5-cycle stall
    out_ready[1] = 1'b0;
    in_data[1]   = 48'h000000000FC0;
    in_valid[1]  = 1'b1;
    exp_q.push_back(expw(32'hEFA72CCD));
    tick();
    in_valid[1] = 1'b0;
    wait_valid(1, 20, n);
    chk("l2_latency", 32'(n), 32'd4);
    held = exp_q.pop_front();
    chk("l2_data", out_data[1], held);
    in_data[1]  = 48'h0;
    in_valid[1] = 1'b1;
    exp_q.push_back(expw(32'hEFA72C4D));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", 32'(out_valid[1]), 32'd1);
      chk("stall_data", out_data[1], held);
      chk("stall_in_ready", 32'(in_ready[1]), 32'd0);
    end

    // Back-to-back: output handshake and next accept on the same edge
    out_ready[1] = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready[1]), 32'd1);
    tick();
    in_valid[1] = 1'b0;
    chk("b2b_accepted", 32'({out_valid[1], busy[1]}), 32'b01);
    wait_valid(1, 20, n);
    chk("b2b_interval", 32'(n + 1), 32'd5);
    chk("b2b_data", out_data[1], exp_q.pop_front());
    tick();
    chk("b2b_idle", 32'({out_valid[1], busy[1]}), 32'd0);

    // Reset in the middle of a LANES=1 run
    out_ready[0] = 1'b1;
    in_data[0]   = 48'hFFFFFFFFFFFF;
    in_valid[0]  = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready_low", 32'(in_ready[2]), 32'd0);
    tick();
    chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort_out_data", out_data[0], 32'h0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    wait_valid(0, 12, n);
    chk("abort_no_result", 32'(out_valid[0]), 32'd0);
    in_data[0]  = 48'h0;
    in_valid[0] = 1'b1;
    exp_q.push_back(expw(32'hEFA72C4D));
    tick();
    in_valid[0] = 1'b0;
    wait_valid(0, 20, n);
    chk("after_abort_latency", 32'(n), 32'd8);
    chk("after_abort_data", out_data[0], exp_q.pop_front());
    tick();
    chk("after_abort_idle", 32'(out_valid[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
